// File: rtl/draw_fill.sv
// AXI4 write-master rectangle filler: streams 128-byte bursts of one color
// into a frame buffer, one burst in flight at a time.
module draw_fill #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 64
) (
  input  logic                               ACLK,
  input  logic                               ARST,
  input  logic                               START,
  input  logic [31:0]                        FILLADDR,
  input  logic [23:0]                        FILLCOLOR,
  input  logic [15:0]                        BURSTS,
  output logic                               BUSY,
  output logic                               DONE,
  output logic                               ERR,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic                               M_AXI_AWLOCK,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic [2:0]                         M_AXI_AWPROT,
  output logic [3:0]                         M_AXI_AWQOS,
  output logic [0:0]                         M_AXI_AWUSER,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic [0:0]                         M_AXI_WUSER,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic [0:0]                         M_AXI_BUSER,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic [0:0]                         M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic [0:0]                         M_AXI_RUSER,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] addr_q, addr_d;
  logic [23:0] color_q, color_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  beat_q, beat_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      color_q <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      color_q <= color_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    color_d = color_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          err_d = 1'b0;
          if (BURSTS != 16'd0) begin
            addr_d  = FILLADDR[31:7];
            color_d = FILLCOLOR;
            cnt_d   = BURSTS;
            state_d = ADDR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (M_AXI_AWREADY) begin
          beat_d  = 4'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (M_AXI_WREADY) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == 4'd15) state_d = RESP;
        end
      end
      RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP[1]) err_d = 1'b1;
          cnt_d  = cnt_q - 16'd1;
          // 128-byte step; 25-bit burst index wraps mod 2^32
          addr_d = addr_q + 25'd1;
          if (cnt_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign ERR  = err_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({addr_q, 7'b0});
  assign M_AXI_AWLEN   = 8'd15;
  assign M_AXI_AWSIZE  = 3'd3;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWUSER  = 1'b0;
  assign M_AXI_AWVALID = (state_q == ADDR);

  assign M_AXI_WDATA  = C_M_AXI_DATA_WIDTH'({8'h00, color_q, 8'h00, color_q});
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WLAST  = (state_q == DATA) && (beat_q == 4'd15);
  assign M_AXI_WUSER  = 1'b0;
  assign M_AXI_WVALID = (state_q == DATA);

  assign M_AXI_BREADY = (state_q == RESP);

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'd0;
  assign M_AXI_ARBURST = 2'b00;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARUSER  = 1'b0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{FILLADDR[6:0], M_AXI_BID, M_AXI_BRESP[0],
                       M_AXI_BUSER, M_AXI_ARREADY, M_AXI_RID,
                       M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
                       M_AXI_RUSER, M_AXI_RVALID};

endmodule

// File: tb/tb_draw_fill.sv
// Scoreboarded bench for draw_fill with a reactive AXI write slave.
// Expected AW addresses and W beats are queued at START and popped at handshakes.
module tb_draw_fill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst, start, busy, done, err;
  logic [31:0] filladdr;
  logic [23:0] fillcolor;
  logic [15:0] bursts;

  logic [0:0]  awid, awuser, wuser, arid, aruser;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp;
  logic        awlock, awvalid, awready, arlock, arvalid, rready;
  logic [3:0]  awcache, awqos, arcache, arqos;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;

  draw_fill dut (
    .ACLK(clk), .ARST(arst), .START(start),
    .FILLADDR(filladdr), .FILLCOLOR(fillcolor), .BURSTS(bursts),
    .BUSY(busy), .DONE(done), .ERR(err),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWUSER(awuser),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WUSER(wuser), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(1'b0), .M_AXI_BRESP(bresp), .M_AXI_BUSER(1'b0),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(1'b0),
    .M_AXI_RID(1'b0), .M_AXI_RDATA(64'd0), .M_AXI_RRESP(2'b00),
    .M_AXI_RLAST(1'b0), .M_AXI_RUSER(1'b0), .M_AXI_RVALID(1'b0),
    .M_AXI_RREADY(rready)
  );

  int vec = 0;
  int miss = 0;

  logic [31:0] exp_aw[$];
  logic [64:0] exp_w[$];

  int aw_delay = 0;
  bit w_rand = 0;
  int err_burst = -1;
  int burst_idx = 0;
  int aw_hs = 0;
  int beats = 0;
  int done_cnt = 0;
  int aw_seen = 0;

  // Reactive slave plus handshake monitor
  initial begin : slave
    bit          b_pending, b_done, aw_hold, w_hold;
    logic [31:0] aw_hold_addr, ea;
    logic [64:0] w_hold_v, ew;
    int          aw_wait;
    b_pending = 0; b_done = 0; aw_hold = 0; w_hold = 0;
    aw_hold_addr = '0; w_hold_v = '0; aw_wait = 0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (arst) begin
        b_pending = 0; b_done = 0; aw_hold = 0; w_hold = 0;
        aw_wait = 0; beats = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      end else begin
        if (b_done) begin
          bvalid = 1'b0;
          b_done = 0;
        end
        if (b_pending) begin
          bvalid = 1'b1;
          bresp = (burst_idx == err_burst) ? 2'b10 : 2'b00;
          b_pending = 0;
        end
        awready = (aw_delay == 0) ? 1'b1 :
                  (awvalid && aw_wait >= aw_delay);
        wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (awvalid) aw_seen++;
        if (aw_hold) begin
          vec++;
          if (awvalid !== 1'b1 || awaddr !== aw_hold_addr) begin
            miss++;
            $display("FAIL aw_stable: got v=%b a=%h expected v=1 a=%h",
                     awvalid, awaddr, aw_hold_addr);
          end
        end
        if (awvalid) begin
          if (awready) begin
            vec++;
            if (exp_aw.size() == 0) begin
              miss++;
              $display("FAIL aw_addr: got %h expected none", awaddr);
            end else begin
              ea = exp_aw.pop_front();
              if (awaddr !== ea) begin
                miss++;
                $display("FAIL aw_addr: got %h expected %h", awaddr, ea);
              end
            end
            aw_hs++;
            aw_hold = 0;
            aw_wait = 0;
            beats = 0;
          end else begin
            aw_hold = 1;
            aw_hold_addr = awaddr;
            aw_wait++;
          end
        end
        if (w_hold) begin
          vec++;
          if (wvalid !== 1'b1 || {wlast, wdata} !== w_hold_v) begin
            miss++;
            $display("FAIL w_stable: got v=%b %h expected v=1 %h",
                     wvalid, {wlast, wdata}, w_hold_v);
          end
        end
        if (wvalid) begin
          if (wready) begin
            vec++;
            if (exp_w.size() == 0) begin
              miss++;
              $display("FAIL w_beat: got %h expected none", {wlast, wdata});
            end else begin
              ew = exp_w.pop_front();
              if ({wlast, wdata} !== ew) begin
                miss++;
                $display("FAIL w_beat: got %h expected %h",
                         {wlast, wdata}, ew);
              end
            end
            beats++;
            w_hold = 0;
            if (wlast) begin
              vec++;
              if (beats !== 16) begin
                miss++;
                $display("FAIL beat_count: got %0d expected 16", beats);
              end
              b_pending = 1;
            end
          end else begin
            w_hold = 1;
            w_hold_v = {wlast, wdata};
          end
        end
        if (bvalid && bready) begin
          b_done = 1;
          burst_idx++;
        end
      end
    end
  end

  initial begin : done_mon
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!arst && done) begin
        vec++;
        if (prev) begin
          miss++;
          $display("FAIL done_pulse: got 2-cycle DONE expected 1 cycle");
        end
        done_cnt++;
      end
      prev = done;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [23:0] c,
                          input logic [15:0] n);
    logic [31:0] base;
    logic [63:0] d;
    base = {a[31:7], 7'b0};
    d = {8'h00, c, 8'h00, c};
    for (int b = 0; b < int'(n); b++) begin
      exp_aw.push_back(base + 32'(b * 128));
      for (int k = 0; k < 16; k++) exp_w.push_back({(k == 15), d});
    end
    tick();
    start = 1'b1;
    filladdr = a;
    fillcolor = c;
    bursts = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == n0; i++) tick();
    got = (done_cnt != n0);
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (3) tick();
    vec++;
    if ({busy, done, err} !== 3'b000) begin
      miss++;
      $display("FAIL rst_status: got %b expected 000", {busy, done, err});
    end
    vec++;
    if ({awvalid, wvalid, bready, wlast} !== 4'b0000) begin
      miss++;
      $display("FAIL rst_axi: got %b expected 0000",
               {awvalid, wvalid, bready, wlast});
    end
    vec++;
    if ({awlen, awsize, awburst, awcache} !== {8'd15, 3'd3, 2'b01, 4'b0011}) begin
      miss++;
      $display("FAIL aw_const: got %h %h %h %h expected 0f 3 1 3",
               awlen, awsize, awburst, awcache);
    end
    vec++;
    if ({awlock, awprot, awqos, awuser, awid} !== '0) begin
      miss++;
      $display("FAIL aw_zero: got %b expected 0",
               {awlock, awprot, awqos, awuser, awid});
    end
    vec++;
    if (wstrb !== 8'hFF || wuser !== 1'b0) begin
      miss++;
      $display("FAIL w_const: got %h %b expected ff 0", wstrb, wuser);
    end
    vec++;
    if ({arvalid, rready, araddr, arlen, arsize, arburst} !== '0) begin
      miss++;
      $display("FAIL ar_tie: got %b %b %h expected 0 0 0",
               arvalid, rready, araddr);
    end
    arst = 1'b0;
    tick();
  endtask

  task automatic test_basic_fill();
    bit got;
    aw_hs = 0; burst_idx = 0;
    do_start(32'h1000_0045, 24'h123456, 16'd2);
    wait_done(400, got);
    vec++;
    if (!got) begin
      miss++;
      $display("FAIL basic_done: got none expected DONE");
    end
    vec++;
    if (aw_hs !== 2 || exp_aw.size() !== 0 || exp_w.size() !== 0) begin
      miss++;
      $display("FAIL basic_sb: got aw=%0d left=%0d/%0d expected 2 0/0",
               aw_hs, exp_aw.size(), exp_w.size());
    end
    vec++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miss++;
      $display("FAIL basic_status: got err=%b busy=%b expected 0 0", err, busy);
    end
  endtask

  task automatic test_stall();
    bit got;
    aw_hs = 0; burst_idx = 0;
    aw_delay = 5; w_rand = 1;
    do_start(32'h2000_0F80, 24'hA5C3E1, 16'd2);
    wait_done(1000, got);
    aw_delay = 0; w_rand = 0;
    vec++;
    if (!got || aw_hs !== 2 || exp_aw.size() !== 0 || exp_w.size() !== 0) begin
      miss++;
      $display("FAIL stall_sb: got done=%b aw=%0d left=%0d expected 1 2 0",
               got, aw_hs, exp_w.size());
    end
  endtask

  task automatic test_zero_bursts();
    int seen0;
    seen0 = aw_seen;
    do_start(32'h3000_0000, 24'h00FF00, 16'd0);
    vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miss++;
      $display("FAIL zero_done: got done=%b busy=%b expected 1 0", done, busy);
    end
    repeat (5) tick();
    vec++;
    if (aw_seen !== seen0 || done !== 1'b0) begin
      miss++;
      $display("FAIL zero_noaw: got aw=%0d done=%b expected %0d 0",
               aw_seen, done, seen0);
    end
  endtask

  task automatic test_bresp_err();
    bit got;
    aw_hs = 0; burst_idx = 0; err_burst = 1;
    do_start(32'h4000_0100, 24'h0F0F0F, 16'd3);
    wait_done(600, got);
    err_burst = -1;
    vec++;
    if (!got || aw_hs !== 3 || exp_w.size() !== 0) begin
      miss++;
      $display("FAIL err_run: got done=%b aw=%0d expected 1 3", got, aw_hs);
    end
    repeat (4) tick();
    vec++;
    if (err !== 1'b1) begin
      miss++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
    aw_hs = 0; burst_idx = 0;
    do_start(32'h4000_1000, 24'h111111, 16'd1);
    vec++;
    if (err !== 1'b0) begin
      miss++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
    wait_done(300, got);
    vec++;
    if (!got || err !== 1'b0 || exp_w.size() !== 0) begin
      miss++;
      $display("FAIL err_after: got done=%b err=%b expected 1 0", got, err);
    end
  endtask

  task automatic test_start_ignored();
    bit got;
    aw_hs = 0; burst_idx = 0;
    do_start(32'h5000_0000, 24'h777777, 16'd2);
    for (int i = 0; i < 50 && !wvalid; i++) tick();
    start = 1'b1;
    filladdr = 32'h6000_0000;
    bursts = 16'd5;
    tick();
    start = 1'b0;
    wait_done(600, got);
    repeat (10) tick();
    vec++;
    if (!got || aw_hs !== 2 || exp_aw.size() !== 0 || busy !== 1'b0) begin
      miss++;
      $display("FAIL ignore: got done=%b aw=%0d busy=%b expected 1 2 0",
               got, aw_hs, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit got;
    int d0;
    aw_hs = 0; burst_idx = 0;
    do_start(32'h7000_0000, 24'hABCDEF, 16'd2);
    for (int i = 0; i < 100 && beats != 7; i++) tick();
    vec++;
    if (beats !== 7) begin
      miss++;
      $display("FAIL mid_reach: got beats=%0d expected 7", beats);
    end
    d0 = done_cnt;
    arst = 1'b1;
    tick();
    vec++;
    if ({awvalid, wvalid, bready, busy} !== 4'b0000) begin
      miss++;
      $display("FAIL mid_rst: got %b expected 0000",
               {awvalid, wvalid, bready, busy});
    end
    arst = 1'b0;
    exp_aw.delete();
    exp_w.delete();
    repeat (5) tick();
    vec++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      miss++;
      $display("FAIL mid_nodone: got done=%0d busy=%b expected %0d 0",
               done_cnt, busy, d0);
    end
    aw_hs = 0; burst_idx = 0;
    do_start(32'h7100_0033, 24'h010203, 16'd1);
    wait_done(300, got);
    vec++;
    if (!got || aw_hs !== 1 || exp_w.size() !== 0) begin
      miss++;
      $display("FAIL mid_refill: got done=%b aw=%0d expected 1 1", got, aw_hs);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    aw_hs = 0; burst_idx = 0;
    do_start(32'hFFFF_FF80, 24'h445566, 16'd2);
    wait_done(400, got);
    do_start(32'h0000_1234, 24'h998877, 16'd1);
    wait_done(300, got);
    vec++;
    if (!got || aw_hs !== 3 || exp_aw.size() !== 0 || exp_w.size() !== 0) begin
      miss++;
      $display("FAIL b2b: got done=%b aw=%0d expected 1 3", got, aw_hs);
    end
  endtask

  initial begin
    arst = 1'b1;
    start = 1'b0;
    filladdr = '0;
    fillcolor = '0;
    bursts = '0;
    test_reset();
    test_basic_fill();
    test_stall();
    test_zero_bursts();
    test_bresp_err();
    test_start_ignored();
    test_reset_mid_burst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/draw_fill.md
DRAW_FILL -- requirements
Module: draw_fill

Interface
REQ-001 SHALL have parameter C_M_AXI_THREAD_ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 64, AXI data width; only 64 is supported.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 ACLK  in  1  sole clock; all logic on its rising edge.
REQ-006 ARST  in  1  synchronous active-high reset.
REQ-007 START  in  1  one-cycle fill request; sampled only in IDLE.
REQ-008 FILLADDR  in  32  frame-buffer byte start address; bits [6:0] are ignored and treated as 0.
REQ-009 FILLCOLOR  in  24  pixel value {R,G,B}; sampled when START is accepted.
REQ-010 BURSTS  in  16  number of 128-byte bursts to write; sampled when START is accepted.
REQ-011 BUSY  out  1  high whenever state is not IDLE.
REQ-012 DONE  out  1  one-cycle completion pulse.
REQ-013 ERR  out  1  sticky; set by any BRESP[1]=1; cleared when the next START is accepted.
REQ-014 M_AXI_AW* / M_AXI_W* / M_AXI_B*  AXI4 write-master ports: AWREADY/AWVALID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWUSER/AWID, WREADY/WVALID/WDATA/WSTRB/WLAST/WUSER, BREADY/BVALID/BRESP/BUSER/BID.
REQ-015 M_AXI_AR* / M_AXI_R*  AXI4 read-master ports, present only for uniform interconnect hookup.

Function
REQ-016 Write-address constants SHALL be: AWLEN=15 (16 beats), AWSIZE=3 (8 bytes), AWBURST=INCR, AWCACHE=4'b0011, AWLOCK/AWPROT/AWQOS/AWUSER/AWID=0.
REQ-017 Write-data constants SHALL be: WSTRB=8'hFF, WUSER=0.
REQ-018 Read channels SHALL be tied off: ARVALID=0, RREADY=0, other AR* outputs=0.
REQ-019 FSM states SHALL be IDLE, ADDR, DATA, RESP.
REQ-020 IDLE with START=1 and BURSTS!=0: latch address {FILLADDR[31:7],7'b0}, color and count; clear ERR; go to ADDR on the next cycle.
REQ-021 IDLE with START=1 and BURSTS=0: clear ERR; pulse DONE on the next cycle; stay IDLE; issue no AXI traffic.
REQ-022 ADDR: AWVALID=1 and AWADDR=current address; both held stable until AWREADY; the handshake cycle moves to DATA.
REQ-023 DATA: WVALID=1 from the cycle after the AW handshake; the beat counter (0-15) advances only on WVALID&WREADY; WVALID is held stable while WREADY=0.
REQ-024 WDATA SHALL be {8'h00,FILLCOLOR,8'h00,FILLCOLOR} (two 32-bit pixels per beat).
REQ-025 WLAST=1 exactly on beat 15; the beat-15 handshake moves to RESP.
REQ-026 RESP: BREADY=1; on BVALID, set ERR if BRESP[1]=1, decrement the remaining count, and add 128 to the address (modulo 2^32).
REQ-027 RESP exit: remaining count 0 -> IDLE with DONE=1 for one cycle; otherwise -> ADDR.
REQ-028 At most one burst SHALL be outstanding; AW is never issued before the prior B is received.
REQ-029 Bursts are 128-byte aligned and therefore never cross a 4 KB boundary.
REQ-030 START while BUSY=1 SHALL be ignored.
REQ-031 After a BRESP error, the fill SHALL continue to completion; ERR remains set.

Reset
REQ-032 ARST=1 SHALL force the following on the next edge: IDLE; AWVALID=WVALID=BREADY=WLAST=0; BUSY=DONE=ERR=0; counters=0.
REQ-033 Reset mid-burst SHALL abandon the transaction with no completion; the interconnect is reset together with this block.

Verification
REQ-034 FILLADDR=0x1000_0045, BURSTS=2, color 0x123456, slave always ready -> AWADDR 0x1000_0000 then 0x1000_0080; 32 beats of WDATA 0x0012_3456_0012_3456; WLAST on beats 15 and 31; one DONE pulse.
REQ-035 AWREADY delayed 5 cycles and WREADY toggled randomly -> AWADDR/WDATA stable while stalled; exactly 16 WVALID&WREADY handshakes per burst.
REQ-036 BURSTS=0 -> DONE high one cycle after START; AWVALID never asserted.
REQ-037 Second-burst BRESP=2'b10, BURSTS=3 -> ERR set after that B, third burst still issued, DONE pulses, ERR held until the next START.
REQ-038 START pulsed during DATA -> ignored; burst count unchanged.
REQ-039 ARST asserted during beat 7 -> next cycle all AXI valids 0, BUSY=0; a new START runs a full fill correctly.
